reg_file_sb: RTL
================

# reg_file_sb

Parametrised write-back register file with two asynchronous read ports, write-to-read bypass and a per-register busy scoreboard. It sits at the WB stage, takes results from the write-back mux and serves operand reads to decode/issue. Issue reserves a destination register, and write-back releases it, so decode can stall on RAW hazards. All register contents are exported flat for debug and LED display.

## Interface

Parameters:
- DATA_W, 16, register width in bits
- NREG, 8, number of registers; must satisfy 2 ≤ NREG ≤ 2**ADDR_W
- ADDR_W, 3, register address width
- ZERO_R0, 0; when 1, register 0 reads as 0 and ignores writes and reservations

Ports:
- CLK_WB  in  1  write-back clock; all state updates on its rising edge
- RESET_N  in  1  synchronous, active-low reset
- WEN  in  1  write enable
- WADDR  in  ADDR_W  write address
- WDATA  in  DATA_W  write data
- RSV_EN  in  1  reserve request (marks a register busy)
- RSV_ADDR  in  ADDR_W  register to reserve
- RADDR_A, RADDR_B  in  ADDR_W  read addresses
- RDATA_A, RDATA_B  out  DATA_W  read data (combinational)
- BUSY_A, BUSY_B  out  1  busy status of RADDR_A / RADDR_B (combinational)
- BUSY_VEC  out  NREG  registered busy bits; bit i is register i
- REG_FLAT  out  DATA_W*NREG  registered contents; register i at bits [i*DATA_W +: DATA_W]

## Operation

- **Valid write:** WEN=1, WADDR<NREG, and not (ZERO_R0=1 and WADDR=0).
- **Valid reserve:** RSV_EN=1, RSV_ADDR<NREG, and not (ZERO_R0=1 and RSV_ADDR=0).
- **Invalid addresses:** invalid writes and reserves are silently dropped. No state changes and no error is raised.
- **Clock edge, reset low:** all registers and busy bits clear to 0. Reset overrides WEN and RSV_EN.
- **Clock edge, reset high:**
  - A valid write stores WDATA into reg[WADDR] and clears busy[WADDR].
  - A valid reserve sets busy[RSV_ADDR].
  - Write and reserve to the same register in the same cycle: data is stored and busy ends set (reserve wins; it is a new producer).
  - Write and reserve to different registers: both take effect.
- **Read path (per port; A shown, B identical):**
  - RADDR_A ≥ NREG: RDATA_A=0 and BUSY_A=0.
  - ZERO_R0=1 and RADDR_A=0: RDATA_A=0 and BUSY_A=0.
  - Valid write this cycle with WADDR=RADDR_A: RDATA_A=WDATA (bypass) and BUSY_A=0 (release bypass).
  - Otherwise: RDATA_A=reg[RADDR_A] and BUSY_A=busy[RADDR_A].
- **Reserve visibility:** a reservation is not bypassed; BUSY_x reflects it from the next cycle.
- **Write to a non-busy register:** legal; the data is stored and busy stays 0.
- **Debug outputs:** REG_FLAT and BUSY_VEC show registered state only, with no bypass.

## Timing

- Write latency: 1 cycle to REG_FLAT. Read-port latency: 0 cycles, via the bypass.
- Reserve latency: 1 cycle to BUSY_VEC and BUSY_x.
- Reset: synchronous. On the first edge with RESET_N=0, all of REG_FLAT and BUSY_VEC become 0. Read-port outputs then follow the rules above.
- Reset mid-operation: a pending write or reserve in the reset cycle is discarded.
- No combinational path from RSV_EN or RSV_ADDR to any output.
- Combinational paths from WEN/WADDR/WDATA to RDATA_x/BUSY_x are intended. The WB mux-to-decode path must be budgeted for them.

## Test plan

- **Reset:** preload every register via writes, set all busy bits, hold RESET_N=0 for 1 edge → REG_FLAT=0 and BUSY_VEC=0; a write issued with reset low is lost.
- **Write/read and bypass:** WEN=1, WADDR=3, WDATA=16'hBEEF, RADDR_A=3 → RDATA_A=BEEF in the same cycle. Next cycle with WEN=0 → RDATA_A=BEEF and REG_FLAT[63:48]=BEEF.
- **Scoreboard:** RSV_EN=1 on reg 5 → BUSY_VEC[5]=1 next cycle. Write reg 5 with 16'h1234 → BUSY_A (RADDR_A=5) drops to 0 in the write cycle and BUSY_VEC[5]=0 after the edge.
- **Simultaneous events:** reg 2 busy; same cycle WEN to reg 2 (16'h00AA) and RSV_EN to reg 2 → reg2=00AA and BUSY_VEC[2]=1. Write reg 4 plus reserve reg 6 in one cycle → reg4 updated, busy[4] cleared, busy[6] set.
- **ZERO_R0=1:** write 16'hFFFF to reg 0 and reserve reg 0 → RDATA_A=0, BUSY_A=0, REG_FLAT[15:0]=0, BUSY_VEC[0]=0. Repeat with ZERO_R0=0 → reg0=FFFF and BUSY_VEC[0]=1.
- **Parametrisation:** DATA_W=32, NREG=6, ADDR_W=3. Write address 7 → no state change; RADDR_B=6 → RDATA_B=0 and BUSY_B=0. Random write/reserve/read for 10k cycles checked against a reference model.

Source files
------------

// File: rtl/reg_file_sb.sv
// Write-back register file: two async read ports with write bypass, per-register
// busy scoreboard (issue reserves, write-back releases) and flat debug exports.
module reg_file_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NREG    = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic                   CLK_WB,
  input  logic                   RESET_N,
  input  logic                   WEN,
  input  logic [ADDR_W-1:0]      WADDR,
  input  logic [DATA_W-1:0]      WDATA,
  input  logic                   RSV_EN,
  input  logic [ADDR_W-1:0]      RSV_ADDR,
  input  logic [ADDR_W-1:0]      RADDR_A,
  input  logic [ADDR_W-1:0]      RADDR_B,
  output logic [DATA_W-1:0]      RDATA_A,
  output logic [DATA_W-1:0]      RDATA_B,
  output logic                   BUSY_A,
  output logic                   BUSY_B,
  output logic [NREG-1:0]        BUSY_VEC,
  output logic [DATA_W*NREG-1:0] REG_FLAT
);

  localparam logic [ADDR_W:0] NREG_C = (ADDR_W+1)'(NREG);

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREG-1:0]             busy_q, busy_d;
  logic                        wr_vld, rsv_vld;
  logic [1:0][ADDR_W-1:0]      raddr;
  logic [1:0][DATA_W-1:0]      rdata;
  logic [1:0]                  rbusy;

  assign wr_vld  = WEN && ({1'b0, WADDR} < NREG_C) && !(ZERO_R0 && (WADDR == '0));
  assign rsv_vld = RSV_EN && ({1'b0, RSV_ADDR} < NREG_C) && !(ZERO_R0 && (RSV_ADDR == '0));

  // Reserve is applied after the write so a same-register pair leaves busy set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (wr_vld && (WADDR == ADDR_W'(i))) begin
        regs_d[i] = WDATA;
        busy_d[i] = 1'b0;
      end
      if (rsv_vld && (RSV_ADDR == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_WB) begin
    if (!RESET_N) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign raddr[0] = RADDR_A;
  assign raddr[1] = RADDR_B;

  // Out-of-range addresses never match a register and so read as zero / not busy.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if ((raddr[p] == ADDR_W'(i)) && !(ZERO_R0 && (i == 0))) begin
          rdata[p] = regs_q[i];
          rbusy[p] = busy_q[i];
        end
      end
      if (wr_vld && (WADDR == raddr[p])) begin
        rdata[p] = WDATA;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign RDATA_A  = rdata[0];
  assign RDATA_B  = rdata[1];
  assign BUSY_A   = rbusy[0];
  assign BUSY_B   = rbusy[1];
  assign BUSY_VEC = busy_q;
  assign REG_FLAT = regs_q;

endmodule
